// File: rtl/battle_damage_engine.sv
// battle_damage_engine: one attack turn, made up of a serial shift-add multiply,
// effectiveness scaling and a saturating HP update for both combatants.
`timescale 1ns/1ps
module battle_damage_engine #(
    parameter int PWR_W = 4,
    parameter int HP_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             init,
    input  logic [HP_W-1:0]  p_hp_init,
    input  logic [HP_W-1:0]  ai_hp_init,
    input  logic [PWR_W-1:0] p_atk_init,
    input  logic [PWR_W-1:0] ai_atk_init,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_attacker,
    input  logic [PWR_W-1:0] req_power,
    input  logic [1:0]       req_mult,
    output logic             done,
    output logic [HP_W-1:0]  dmg_out,
    output logic [HP_W-1:0]  p_hp,
    output logic [HP_W-1:0]  ai_hp,
    output logic             p_fainted,
    output logic             ai_fainted,
    output logic             busy
);
    localparam int PROD_W = 2 * PWR_W;
    localparam int CNT_W  = $clog2(PWR_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PWR_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_SCALE,
        S_APPLY,
        S_DONE
    } state_t;

    state_t             state;
    logic [PWR_W-1:0]   p_atk;
    logic [PWR_W-1:0]   ai_atk;
    logic [PROD_W-1:0]  prod;
    logic [PROD_W-1:0]  mcand;
    logic [PWR_W-1:0]   mplier;
    logic [CNT_W-1:0]   bit_cnt;
    logic               attacker;
    logic [1:0]         mult;
    logic [HP_W-1:0]    dmg;

    logic [HP_W-1:0]    prod_ext;
    logic [HP_W:0]      dbl;
    logic [HP_W-1:0]    scaled;
    logic [HP_W-1:0]    tgt_hp;
    logic [HP_W-1:0]    new_hp;
    logic               accept;

    assign p_fainted  = (p_hp == '0);
    assign ai_fainted = (ai_hp == '0);
    assign busy       = (state != S_IDLE);
    assign req_ready  = (state == S_IDLE) & ~init & ~p_fainted & ~ai_fainted;
    assign accept     = req_valid & req_ready;

    // Doubling is done one bit wider so an overflow can saturate.
    always_comb begin
        prod_ext = HP_W'(prod);
        dbl      = {prod_ext, 1'b0};
        scaled   = '0;
        unique case (mult)
            2'd0: scaled = '0;
            2'd1: scaled = prod_ext >> 1;
            2'd2: scaled = prod_ext;
            2'd3: scaled = dbl[HP_W] ? '1 : dbl[HP_W-1:0];
        endcase
    end

    always_comb begin
        tgt_hp = attacker ? p_hp : ai_hp;
        new_hp = (tgt_hp > dmg) ? tgt_hp - dmg : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            p_hp     <= '0;
            ai_hp    <= '0;
            p_atk    <= '0;
            ai_atk   <= '0;
            dmg_out  <= '0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            bit_cnt  <= '0;
            attacker <= 1'b0;
            mult     <= 2'd0;
            dmg      <= '0;
            done     <= 1'b0;
        end else if (init) begin
            p_hp    <= p_hp_init;
            ai_hp   <= ai_hp_init;
            p_atk   <= p_atk_init;
            ai_atk  <= ai_atk_init;
            dmg_out <= '0;
            done    <= 1'b0;
            state   <= S_IDLE;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        attacker <= req_attacker;
                        mult     <= req_mult;
                        mplier   <= req_power;
                        mcand    <= PROD_W'(req_attacker ? ai_atk : p_atk);
                        prod     <= '0;
                        bit_cnt  <= '0;
                        state    <= S_MUL;
                    end
                end
                // Multiplicand shifts left as the multiplier shifts right.
                S_MUL: begin
                    if (mplier[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    dmg   <= scaled;
                    state <= S_APPLY;
                end
                S_APPLY: begin
                    if (attacker) begin
                        p_hp <= new_hp;
                    end else begin
                        ai_hp <= new_hp;
                    end
                    dmg_out <= dmg;
                    done    <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_battle_damage_engine.sv
// Scoreboard bench for battle_damage_engine: a reference HP/attack model
// queues expected results, which are popped and compared when done pulses.
`timescale 1ns/1ps
module tb_battle_damage_engine;

    typedef struct {
        int dmg;
        int p;
        int ai;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       init = 1'b0;
    logic [7:0] p_hp_init = '0;
    logic [7:0] ai_hp_init = '0;
    logic [3:0] p_atk_init = '0;
    logic [3:0] ai_atk_init = '0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_attacker = 1'b0;
    logic [3:0] req_power = '0;
    logic [1:0] req_mult = '0;
    logic       done;
    logic [7:0] dmg_out;
    logic [7:0] p_hp;
    logic [7:0] ai_hp;
    logic       p_fainted;
    logic       ai_fainted;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;
    int p_hp_m, ai_hp_m, p_atk_m, ai_atk_m;
    exp_t sb[$];

    battle_damage_engine #(.PWR_W(4), .HP_W(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .init(init),
        .p_hp_init(p_hp_init),
        .ai_hp_init(ai_hp_init),
        .p_atk_init(p_atk_init),
        .ai_atk_init(ai_atk_init),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_attacker(req_attacker),
        .req_power(req_power),
        .req_mult(req_mult),
        .done(done),
        .dmg_out(dmg_out),
        .p_hp(p_hp),
        .ai_hp(ai_hp),
        .p_fainted(p_fainted),
        .ai_fainted(ai_fainted),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int model_dmg(input int att, input int pw, input int ml);
        int prod;
        prod = (att != 0 ? ai_atk_m : p_atk_m) * pw;
        case (ml)
            0: return 0;
            1: return prod / 2;
            2: return prod;
            default: return (prod * 2 > 255) ? 255 : prod * 2;
        endcase
    endfunction

    task automatic push_exp(input int att, input int pw, input int ml);
        int d;
        exp_t e;
        d = model_dmg(att, pw, ml);
        if (att != 0) p_hp_m = (p_hp_m > d) ? p_hp_m - d : 0;
        else ai_hp_m = (ai_hp_m > d) ? ai_hp_m - d : 0;
        e.dmg = d;
        e.p = p_hp_m;
        e.ai = ai_hp_m;
        sb.push_back(e);
    endtask

    task automatic do_init(input int ph, input int ah, input int pa, input int aa);
        @(negedge clk);
        p_hp_init = 8'(ph);
        ai_hp_init = 8'(ah);
        p_atk_init = 4'(pa);
        ai_atk_init = 4'(aa);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        p_hp_m = ph;
        ai_hp_m = ah;
        p_atk_m = pa;
        ai_atk_m = aa;
    endtask

    task automatic send_req(input int att, input int pw, input int ml, output bit ok);
        @(negedge clk);
        req_attacker = att[0];
        req_power = 4'(pw);
        req_mult = 2'(ml);
        req_valid = 1'b1;
        ok = req_ready;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int low, output bit seen);
        lat = 0;
        low = 0;
        seen = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (!req_ready) low++;
            if (done) begin
                lat = n;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (p_hp !== 8'd0 || ai_hp !== 8'd0 || dmg_out !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_regs: p_hp=%0d ai_hp=%0d dmg=%0d want 0", p_hp, ai_hp, dmg_out);
        end
        tests_run++;
        if ({p_fainted, ai_fainted, req_ready, done, busy} !== 5'b11000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 11000", {p_fainted, ai_fainted, req_ready, done, busy});
        end
    endtask

    task automatic test_basic;
        bit ok, seen;
        int lat, low;
        exp_t e;
        do_init(100, 50, 5, 7);
        push_exp(0, 6, 2);
        send_req(0, 6, 2, ok);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_ready: got %0b want 1", ok);
        end
        wait_done(lat, low, seen);
        e = sb.pop_front();
        tests_run++;
        if (!seen || lat != 7) begin
            tests_failed++;
            $display("FAIL basic_latency: seen=%0b lat=%0d want 7", seen, lat);
        end
        tests_run++;
        if (dmg_out !== 8'(e.dmg) || ai_hp !== 8'(e.ai) || p_hp !== 8'(e.p)) begin
            tests_failed++;
            $display("FAIL basic_result: dmg=%0d ai=%0d p=%0d want %0d %0d %0d", dmg_out, ai_hp, p_hp, e.dmg, e.ai, e.p);
        end
        @(negedge clk);
        tests_run++;
        if (low != 7 || done !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_ready_gap: low=%0d done=%0b ready=%0b want 7 0 1", low, done, req_ready);
        end
    endtask

    task automatic test_sequence;
        bit ok, seen;
        int lat, low;
        exp_t e;
        push_exp(1, 3, 3);
        send_req(1, 3, 3, ok);
        wait_done(lat, low, seen);
        e = sb.pop_front();
        tests_run++;
        if (!ok || !seen || dmg_out !== 8'(e.dmg) || p_hp !== 8'(e.p) || ai_hp !== 8'(e.ai)) begin
            tests_failed++;
            $display("FAIL ai_double: dmg=%0d p=%0d ai=%0d want %0d %0d %0d", dmg_out, p_hp, ai_hp, e.dmg, e.p, e.ai);
        end
        push_exp(0, 9, 1);
        send_req(0, 9, 1, ok);
        wait_done(lat, low, seen);
        e = sb.pop_front();
        tests_run++;
        if (!ok || !seen || dmg_out !== 8'(e.dmg) || ai_hp !== 8'(e.ai) || p_hp !== 8'(e.p)) begin
            tests_failed++;
            $display("FAIL half_sat: dmg=%0d ai=%0d p=%0d want %0d %0d %0d", dmg_out, ai_hp, p_hp, e.dmg, e.ai, e.p);
        end
        tests_run++;
        if (ai_fainted !== 1'b1) begin
            tests_failed++;
            $display("FAIL faint_with_done: ai_fainted=%0b want 1", ai_fainted);
        end
        @(negedge clk);
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (req_ready !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL fainted_block: ready=%0b busy=%0b want 0 0", req_ready, busy);
            end
        end
        req_valid = 1'b0;
        tests_run++;
        if (ai_hp !== 8'(ai_hp_m) || p_hp !== 8'(p_hp_m)) begin
            tests_failed++;
            $display("FAIL fainted_hold: ai=%0d p=%0d want %0d %0d", ai_hp, p_hp, ai_hp_m, p_hp_m);
        end
    endtask

    task automatic test_saturation;
        bit ok, seen;
        int lat, low;
        exp_t e;
        do_init(255, 255, 15, 15);
        push_exp(0, 15, 3);
        send_req(0, 15, 3, ok);
        wait_done(lat, low, seen);
        e = sb.pop_front();
        tests_run++;
        if (!ok || !seen || dmg_out !== 8'(e.dmg) || ai_hp !== 8'(e.ai)) begin
            tests_failed++;
            $display("FAIL dmg_saturate: dmg=%0d ai=%0d want %0d %0d", dmg_out, ai_hp, e.dmg, e.ai);
        end
        do_init(255, 255, 15, 15);
        tests_run++;
        if (ai_fainted !== 1'b0 || dmg_out !== 8'd0) begin
            tests_failed++;
            $display("FAIL reinit: fainted=%0b dmg=%0d want 0 0", ai_fainted, dmg_out);
        end
        push_exp(0, 12, 0);
        send_req(0, 12, 0, ok);
        wait_done(lat, low, seen);
        e = sb.pop_front();
        tests_run++;
        if (!ok || !seen || lat != 7 || dmg_out !== 8'(e.dmg) || ai_hp !== 8'(e.ai) || p_hp !== 8'(e.p)) begin
            tests_failed++;
            $display("FAIL mult_zero: seen=%0b dmg=%0d ai=%0d p=%0d want 1 %0d %0d %0d", seen, dmg_out, ai_hp, p_hp, e.dmg, e.ai, e.p);
        end
        push_exp(1, 0, 2);
        send_req(1, 0, 2, ok);
        wait_done(lat, low, seen);
        e = sb.pop_front();
        tests_run++;
        if (!ok || !seen || dmg_out !== 8'(e.dmg) || p_hp !== 8'(e.p)) begin
            tests_failed++;
            $display("FAIL power_zero: seen=%0b dmg=%0d p=%0d want 1 %0d %0d", seen, dmg_out, p_hp, e.dmg, e.p);
        end
    endtask

    task automatic test_capture_abort;
        bit ok, seen;
        int lat, low, ndone;
        exp_t e;
        do_init(200, 200, 3, 4);
        push_exp(0, 2, 2);
        send_req(0, 2, 2, ok);
        req_attacker = 1'b1;
        req_power = 4'd15;
        req_mult = 2'd3;
        wait_done(lat, low, seen);
        e = sb.pop_front();
        tests_run++;
        if (!ok || !seen || dmg_out !== 8'(e.dmg) || ai_hp !== 8'(e.ai) || p_hp !== 8'(e.p)) begin
            tests_failed++;
            $display("FAIL capture: dmg=%0d ai=%0d p=%0d want %0d %0d %0d", dmg_out, ai_hp, p_hp, e.dmg, e.ai, e.p);
        end
        send_req(1, 5, 2, ok);
        repeat (2) @(negedge clk);
        p_hp_init = 8'd77;
        ai_hp_init = 8'd66;
        p_atk_init = 4'd4;
        ai_atk_init = 4'd9;
        init = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL init_in_mul: ready=%0b busy=%0b want 0 1", req_ready, busy);
        end
        @(negedge clk);
        init = 1'b0;
        p_hp_m = 77;
        ai_hp_m = 66;
        p_atk_m = 4;
        ai_atk_m = 9;
        #1;
        tests_run++;
        if (p_hp !== 8'd77 || ai_hp !== 8'd66 || dmg_out !== 8'd0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_state: p=%0d ai=%0d dmg=%0d ready=%0b want 77 66 0 1", p_hp, ai_hp, dmg_out, req_ready);
        end
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        tests_run++;
        if (ndone != 0 || p_hp !== 8'd77 || ai_hp !== 8'd66) begin
            tests_failed++;
            $display("FAIL abort_no_done: dones=%0d p=%0d ai=%0d want 0 77 66", ndone, p_hp, ai_hp);
        end
    endtask

    task automatic test_async_reset;
        bit ok, seen;
        int lat, low, ndone;
        exp_t e;
        do_init(150, 150, 6, 6);
        push_exp(0, 4, 2);
        send_req(0, 4, 2, ok);
        wait_done(lat, low, seen);
        e = sb.pop_front();
        tests_run++;
        if (!ok || !seen || dmg_out !== 8'(e.dmg) || ai_hp !== 8'(e.ai)) begin
            tests_failed++;
            $display("FAIL pre_reset: dmg=%0d ai=%0d want %0d %0d", dmg_out, ai_hp, e.dmg, e.ai);
        end
        send_req(1, 4, 2, ok);
        repeat (5) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL in_scale: busy=%0b done=%0b want 1 0", busy, done);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (p_hp !== 8'd0 || ai_hp !== 8'd0 || dmg_out !== 8'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_clear: p=%0d ai=%0d dmg=%0d busy=%0b want 0 0 0 0", p_hp, ai_hp, dmg_out, busy);
        end
        tests_run++;
        if ({p_fainted, ai_fainted, req_ready, done} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL async_flags: got %b want 1100", {p_fainted, ai_fainted, req_ready, done});
        end
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        tests_run++;
        if (ndone != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset: dones=%0d busy=%0b want 0 0", ndone, busy);
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sequence();
        test_saturation();
        test_capture_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/battle_damage_engine.md
Name: battle_damage_engine

Overview:
- Sequences one attack turn of the battle: accepts an attack request, computes damage with a serial shift-add multiplier, scales it by type effectiveness, and applies it with saturation to the target's HP register.
- Owns both combatants' HP and attack-stat registers.
- Sits between the turn-control FSM, which issues requests and watches `done` and the fainted flags, and the display logic.

Parameters:
- PWR_W, 4, width of move power and of attack stats.
- HP_W, 8, width of HP and damage. Must satisfy HP_W >= 2*PWR_W.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- init  in  1  load HP and attack registers; highest synchronous priority.
- p_hp_init  in  HP_W  player HP loaded on init.
- ai_hp_init  in  HP_W  AI HP loaded on init.
- p_atk_init  in  PWR_W  player attack stat loaded on init.
- ai_atk_init  in  PWR_W  AI attack stat loaded on init.
- req_valid  in  1  attack request.
- req_ready  out  1  engine can accept a request.
- req_attacker  in  1  0 = player attacks AI, 1 = AI attacks player.
- req_power  in  PWR_W  move power.
- req_mult  in  2  effectiveness: 0 none, 1 half, 2 normal, 3 double.
- done  out  1  one-cycle pulse when HP has been updated.
- dmg_out  out  HP_W  damage applied by the last completed request.
- p_hp  out  HP_W  player HP.
- ai_hp  out  HP_W  AI HP.
- p_fainted  out  1  p_hp == 0.
- ai_fainted  out  1  ai_hp == 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - All registers clear: HP, attack stats, dmg_out, product, done = 0, state = IDLE.
  - As a result p_fainted = ai_fainted = 1 and req_ready = 0 until init.
- req_ready is combinational: (state == IDLE) & !init & !p_fainted & !ai_fainted.
- Handshake:
  - A request is accepted on the clock edge where req_valid & req_ready are both high.
  - req_attacker, req_power and req_mult are captured at that edge. Later input changes have no effect.
- States: IDLE, MUL, SCALE, APPLY, DONE.
  - IDLE -> MUL on accept. Clears the product, loads the multiplicand with the attacker's attack stat and the multiplier with req_power.
  - MUL lasts exactly PWR_W cycles, one multiplier bit per cycle, LSB first: if bit set, product += multiplicand << i. Product width is 2*PWR_W, so there is no overflow. Transitions to SCALE after the last bit.
  - SCALE computes dmg as follows, then -> APPLY:
    - mult 0 -> 0
    - mult 1 -> product >> 1 (floor)
    - mult 2 -> product
    - mult 3 -> product << 1, saturated to 2^HP_W - 1
  - APPLY:
    - Target HP <= (hp > dmg) ? hp - dmg : 0. Saturates at zero and never wraps.
    - dmg_out <= dmg. The non-target HP is unchanged. Then -> DONE.
  - DONE: done = 1 for this single cycle; -> IDLE.
- Latency:
  - With acceptance at edge E0, HP and dmg_out change at edge E0+PWR_W+2.
  - done is high in the cycle following that edge.
  - req_ready can be high again one cycle after done.
  - Fixed total: PWR_W+3 cycles from accept to the next possible accept.
- dmg_out holds its value until the next APPLY or init.
- init:
  - Sampled every cycle, in any state.
  - Loads all four init values, clears dmg_out, forces state = IDLE and aborts any in-flight request: no HP change, no done.
  - req_ready is low in any cycle where init is high.
- Fainted:
  - Once either HP reaches 0, req_ready stays low until init.
  - The fainted flag is visible in the same cycle as done.
  - init values of 0 give immediate fainted.
- A zero-damage request (mult 0 or power 0) still runs the full sequence and pulses done.

Test Plan:
1. Reset low, then high -> p_hp = ai_hp = dmg_out = 0, p_fainted = ai_fainted = 1, req_ready = 0, done = 0.
2. init with p_hp 100, ai_hp 50, p_atk 5, ai_atk 7. Player request with power 6, mult 2.
   -> dmg_out 30, ai_hp 20, p_hp 100.
   -> done is a single pulse in the cycle after edge E0+6 (PWR_W = 4).
   -> req_ready is low for exactly 7 cycles.
3. Continue: AI request with power 3, mult 3 -> dmg 42, p_hp 58. Then player request with power 9, mult 1 -> dmg 22, ai_hp 0 (saturated, not wrapped), ai_fainted = 1, req_ready stays 0 while req_valid is held high.
4. init with atk 15 on both sides, HP 255. Player request with power 15, mult 3 -> dmg_out 255, ai_hp 0. Then re-init; a request with mult 0 -> dmg_out 0, HP unchanged, done still pulses.
5. Accept a request, change req_power/req_mult during MUL -> result uses the captured values. Assert init in the MUL state -> no done, HP equals the init values, dmg_out 0, req_ready high the cycle after init drops.
6. Drop reset_n asynchronously during SCALE -> all outputs clear immediately without waiting for a clock edge, and no done is produced afterwards.
